// File: rtl/ps2_host_tx_if.sv
// Bus interface for the PS/2 host transmitter.
// Shares the 32-bit address/data bus with the ROM controller.
//   addr  : bus address, addr[31:24] selects the block, addr[3:2] the register
//   wdata : write data
//   we    : write strobe, one cycle per write
//   data  : read data, driven combinationally by the slave
// The master modport belongs to the CPU side and the slave modport to the transmitter.
interface ps2_host_tx_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] data;

  modport master (
    output addr,
    output wdata,
    output we,
    input  data
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    output data
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Memory-mapped PS/2 host-to-device transmitter.
// The CPU writes a command byte to TXDATA. The block runs the request-to-send sequence:
// it inhibits the clock, then asserts the start bit and releases the clock. It shifts the
// byte out LSB first, then odd parity and the stop bit, on falls of the device clock.
// Finally it samples the device ACK and waits for both lines to go idle.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   bus          : slave side of the shared address/data bus
//                  (TXDATA at offset 0, STATUS at offset 1)
//   ps2_clk_in   : raw PS/2 clock line (asynchronous)
//   ps2_data_in  : raw PS/2 data line (asynchronous)
//   ps2_clk_oe   : 1 pulls the PS/2 clock low
//   ps2_data_oe  : 1 pulls the PS/2 data low
// STATUS reads {28'h0, busy, timeout, ack_err, done}. Writing STATUS with wdata[0]=1 clears
// the three flags.
module ps2_host_tx #(
  parameter logic [7:0]  BASE           = 8'h21,
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  // One counter serves the inhibit phase and the transfer timeout.
  // The two phases never overlap.
  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES :
                                                                        TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StData,
    StParity,
    StStop,
    StAck,
    StWaitIdle
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        byte_q, byte_d;
  logic              parity_q, parity_d;
  logic              done_q, done_d;
  logic              ack_err_q, ack_err_d;
  logic              timeout_q, timeout_d;
  logic              clk_oe_q, clk_oe_d;
  logic              data_oe_q, data_oe_d;

  // Bus decode
  logic       sel;
  logic [1:0] offset;
  logic       wr_tx;
  logic       wr_stat;
  logic       busy;

  assign sel     = (bus.addr[31:24] == BASE);
  assign offset  = bus.addr[3:2];
  assign wr_tx   = sel & bus.we & (offset == 2'd0);
  assign wr_stat = sel & bus.we & (offset == 2'd1);
  assign busy    = (state_q != StIdle);

  assign bus.data = (sel && offset == 2'd1) ? {28'h0, busy, timeout_q, ack_err_q, done_q} :
                                              32'h0;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.addr[23:4], bus.addr[1:0], bus.wdata[31:8]};

  // Two-flop synchronizers plus one history flop on the clock for fall detection.
  // The line change is acted on at the third clk edge after it arrives.
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b0;
      clk_sync_q  <= 1'b0;
      clk_prev_q  <= 1'b0;
      data_meta_q <= 1'b0;
      data_sync_q <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  // Next-state, flag and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    parity_d  = parity_q;
    done_d    = done_q;
    ack_err_d = ack_err_q;
    timeout_d = timeout_q;

    // Flag clear from STATUS. Anything the FSM sets below wins over it.
    if (wr_stat && bus.wdata[0]) begin
      done_d    = 1'b0;
      ack_err_d = 1'b0;
      timeout_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (wr_tx) begin
          byte_d    = bus.wdata[7:0];
          parity_d  = ~^bus.wdata[7:0];
          done_d    = 1'b0;
          ack_err_d = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = StInhibit;
        end
      end

      // Falls here come from our own clock pull-down and are ignored.
      StInhibit: begin
        if (cnt_q == InhibitLast) begin
          cnt_d   = '0;
          state_d = StReq;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StReq, StData, StParity, StStop: begin
        if (cnt_q == TimeoutLast) begin
          // The device stopped clocking. Abandon the transfer without setting done.
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (fall) begin
            case (state_q)
              StReq: begin
                idx_d   = 3'd0;
                state_d = StData;
              end
              StData: begin
                if (idx_q == 3'd7) begin
                  state_d = StParity;
                end else begin
                  idx_d = idx_q + 3'd1;
                end
              end
              StParity: state_d = StStop;
              StStop:   state_d = StAck;
              default:  state_d = state_q;
            endcase
          end
        end
      end

      StAck: begin
        // The device acknowledges by holding data low.
        if (data_sync_q) begin
          ack_err_d = 1'b1;
        end
        state_d = StWaitIdle;
      end

      StWaitIdle: begin
        if (clk_sync_q && data_sync_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    // Line drives are registered from the next state to keep the open-drain enables glitch-free.
    // Each data bit therefore changes on the same edge that acts on the fall.
    clk_oe_d = (state_d == StInhibit);
    case (state_d)
      StReq:    data_oe_d = 1'b1;
      StData:   data_oe_d = ~byte_q[idx_d];
      StParity: data_oe_d = ~parity_q;
      default:  data_oe_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      byte_q    <= 8'h00;
      parity_q  <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      parity_q  <= parity_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
